ace_snapshot_loader: RTL and testbench

// - Decodes a compressed .ACE snapshot from the HPS ioctl download stream into byte writes to Jupiter Ace RAM.
// - Sits between hps_io (ioctl_*) and the ace core's loader write port (loader_addr/data/wr/en) and holds the core in reset at load start.
// - Encoding: plain bytes are literals; ED nn bb repeats bb nn times (nn=1..255); ED 00 ends the image.

---
 rtl/ace_loader_pkg.sv | 18 +
 rtl/ace_snapshot_loader.sv | 125 ++++++++++++
 tb/tb_ace_snapshot_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_loader_pkg.sv
// Shared types and defaults for the Jupiter Ace .ACE snapshot loader.
package ace_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_LIT,
    ST_CNT,
    ST_VAL,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [15:0] LOAD_BASE_DEFAULT  = 16'h2000;
  localparam int unsigned RST_CYCLES_DEFAULT = 16;
  localparam logic [7:0]  ESC_DEFAULT        = 8'hED;

endpackage

// File: rtl/ace_snapshot_loader.sv
// Decodes an RLE-compressed .ACE image from the ioctl download stream into
// sequential RAM writes, holding the core in reset while the load starts.
module ace_snapshot_loader
  import ace_loader_pkg::*;
#(
  parameter logic [15:0] LOAD_BASE  = LOAD_BASE_DEFAULT,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEFAULT,
  parameter logic [7:0]  ESC        = ESC_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        loader_en,
  output logic        loader_wr,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        loader_reset,
  output logic        load_err
);

  state_t      r_state, w_state_nxt;
  logic        r_dl_prev, r_wr, r_err, r_full;
  logic [15:0] r_addr, r_rcnt;
  logic [7:0]  r_data, r_cnt, r_bb;
  logic        w_start, w_hold, w_take, w_issue, w_blocked, w_loading;
  logic [7:0]  w_issue_data;

  assign w_start   = (r_state == ST_IDLE) && ioctl_download && !r_dl_prev &&
                     (ioctl_index != 8'd0);
  assign w_hold    = (r_state == ST_RST) || (r_state == ST_RUN);
  assign w_take    = ioctl_wr && ioctl_download && !w_hold;
  // A write still on the bus at FFFF counts as filling memory already.
  assign w_blocked = r_full || (r_wr && (r_addr == 16'hFFFF));
  assign w_loading = (r_state == ST_LIT) || (r_state == ST_CNT) ||
                     (r_state == ST_VAL) || (r_state == ST_RUN);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RST;
      ST_RST:  if (r_rcnt == '0) w_state_nxt = ST_LIT;
      ST_LIT:  if (w_take && (ioctl_dout == ESC)) w_state_nxt = ST_CNT;
      ST_CNT:  if (w_take) w_state_nxt = (ioctl_dout == 8'd0) ? ST_DONE : ST_VAL;
      ST_VAL:  if (w_take) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_LIT;
      default: w_state_nxt = r_state;
    endcase
    if (!ioctl_download) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    ioctl_wait   = w_hold;
    loader_reset = (r_state == ST_RST);
    loader_en    = (r_state != ST_IDLE);
    w_issue      = 1'b0;
    w_issue_data = '0;
    case (r_state)
      ST_LIT: begin
        w_issue      = w_take && (ioctl_dout != ESC);
        w_issue_data = ioctl_dout;
      end
      ST_RUN: begin
        w_issue      = (r_cnt != '0) && ioctl_download;
        w_issue_data = r_bb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_prev <= 1'b0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_full    <= 1'b0;
      r_addr    <= LOAD_BASE;
      r_rcnt    <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_bb      <= '0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_wr      <= 1'b0;
      if (w_start) begin
        r_addr <= LOAD_BASE;
        r_err  <= 1'b0;
        r_full <= 1'b0;
        r_rcnt <= 16'(RST_CYCLES - 1);
      end else if ((r_state == ST_RST) && (r_rcnt != '0)) begin
        r_rcnt <= r_rcnt - 16'd1;
      end
      if (r_wr) begin
        if (r_addr == 16'hFFFF) r_full <= 1'b1;
        else                    r_addr <= r_addr + 16'd1;
      end
      if (w_issue) begin
        if (w_blocked) begin
          r_err <= 1'b1;
        end else begin
          r_wr   <= 1'b1;
          r_data <= w_issue_data;
        end
      end
      if (w_take && (r_state == ST_CNT) && (ioctl_dout != 8'd0)) r_cnt <= ioctl_dout;
      if (w_take && (r_state == ST_VAL)) r_bb <= ioctl_dout;
      if ((r_state == ST_RUN) && (r_cnt != '0)) r_cnt <= r_cnt - 8'd1;
      if (!ioctl_download && w_loading) r_err <= 1'b1;
    end
  end

  assign loader_wr   = r_wr;
  assign loader_addr = r_addr;
  assign loader_data = r_data;
  assign load_err    = r_err;

endmodule

// File: tb/tb_ace_snapshot_loader.sv
// Bench for ace_snapshot_loader: table vectors, random streams against a
// byte-level decoder model, and hand-written timing sequences.
module tb_ace_snapshot_loader;

  typedef logic [23:0] wr_t;
  typedef struct {
    logic [7:0]  idx;
    int unsigned len;
    logic [63:0] bytes;
    int unsigned n_a;
    logic [15:0] addr_a;
    logic        err_a;
    int unsigned n_b;
    logic [15:0] addr_b;
    logic        err_b;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic        wait_a, en_a, wr_a, rst_a, err_a;
  logic        wait_b, en_b, wr_b, rst_b, err_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  wr_t         cap_a[$], cap_b[$], exp_q[$];
  logic [7:0]  strm[$];
  logic        ctl_seen;
  logic        mdl_err_a = 1'b0, mdl_err_b = 1'b0;
  logic [15:0] mdl_addr_a = 16'h2000, mdl_addr_b = 16'hFFFE;
  vec_t        tbl[9];

  always #5 clk_sys = ~clk_sys;

  ace_snapshot_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(wait_a), .loader_en(en_a), .loader_wr(wr_a),
    .loader_addr(addr_a), .loader_data(data_a), .loader_reset(rst_a),
    .load_err(err_a)
  );

  ace_snapshot_loader #(.LOAD_BASE(16'hFFFE)) dut_hi (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(wait_b), .loader_en(en_b), .loader_wr(wr_b),
    .loader_addr(addr_b), .loader_data(data_b), .loader_reset(rst_b),
    .load_err(err_b)
  );

  always @(negedge clk_sys) begin
    if (wr_a) cap_a.push_back({addr_a, data_a});
    if (wr_b) cap_b.push_back({addr_b, data_b});
    if (en_a | rst_a | wait_a | wr_a | en_b | rst_b | wait_b | wr_b) ctl_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decodes strm as a whole image: literal bytes, ED n b runs, ED 00 end.
  function automatic void model(input logic [15:0] base, output logic err,
                                output logic [15:0] fin);
    int next = int'(base);
    int i = 0;
    bit done = 0;
    err = 1'b0;
    exp_q.delete();
    while (i < strm.size() && !done) begin
      if (strm[i] != 8'hED) begin
        if (next <= 'hFFFF) begin exp_q.push_back({next[15:0], strm[i]}); next++; end
        else err = 1'b1;
        i++;
      end else if (i + 1 >= strm.size()) begin
        i = strm.size();
      end else if (strm[i+1] == 8'd0) begin
        done = 1;
      end else if (i + 2 >= strm.size()) begin
        i = strm.size();
      end else begin
        for (int k = 0; k < int'(strm[i+1]); k++) begin
          if (next <= 'hFFFF) begin exp_q.push_back({next[15:0], strm[i+2]}); next++; end
          else err = 1'b1;
        end
        i += 3;
      end
    end
    if (!done) err = 1'b1;
    fin = (next > 'hFFFF) ? 16'hFFFF : next[15:0];
  endfunction

  task automatic cmp_writes(input string tag, input bit hi);
    wr_t c[$];
    if (hi) c = cap_b; else c = cap_a;
    check({tag, "/nwrites"}, c.size(), exp_q.size());
    for (int i = 0; i < c.size() && i < exp_q.size(); i++)
      check($sformatf("%s/write%0d", tag, i), c[i], exp_q[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned g = 0;
    while (wait_a && g < 600) begin @(negedge clk_sys); g++; end
    if (wait_a) check("wait_release", wait_a, 0);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx, output int unsigned nrst,
                          output int unsigned nwait);
    nrst = 0;
    nwait = 0;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (rst_a) nrst++;
      if (wait_a) nwait++;
      if (nrst > 0 && !rst_a) break;
    end
  endtask

  task automatic run_vec(input string tag, input logic [7:0] idx, input bit gaps);
    int unsigned nr, nw, g;
    cap_a.delete();
    cap_b.delete();
    ctl_seen = 1'b0;
    start_dl(idx, nr, nw);
    check({tag, "/rst_cycles"}, nr, (idx != 0) ? 16 : 0);
    check({tag, "/start_wait_cycles"}, nw, (idx != 0) ? 16 : 0);
    foreach (strm[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      send_byte(strm[i]);
    end
    g = 0;
    while (wait_a && g < 600) begin @(negedge clk_sys); g++; end
    repeat (3) @(negedge clk_sys);
    check({tag, "/en_loading"}, en_a, idx != 0);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check({tag, "/en_after_drop"}, en_a, 0);
    check({tag, "/wait_after_drop"}, wait_a, 0);
    if (idx == 0) begin
      check({tag, "/idx0_quiet"}, ctl_seen, 0);
      exp_q.delete();
      cmp_writes({tag, "/a"}, 0);
      cmp_writes({tag, "/b"}, 1);
    end else begin
      model(16'h2000, mdl_err_a, mdl_addr_a);
      cmp_writes({tag, "/a"}, 0);
      model(16'hFFFE, mdl_err_b, mdl_addr_b);
      cmp_writes({tag, "/b"}, 1);
    end
    check({tag, "/a_err"}, err_a, mdl_err_a);
    check({tag, "/a_addr"}, addr_a, mdl_addr_a);
    check({tag, "/b_err"}, err_b, mdl_err_b);
    check({tag, "/b_addr"}, addr_b, mdl_addr_b);
  endtask

  initial begin
    int unsigned nr, nw, nc;
    logic [63:0] tmp;
    logic [7:0]  b;

    tbl[0] = '{8'd0, 3, 64'h112233_0000000000, 0, 16'h2000, 1'b0, 0, 16'hFFFE, 1'b0};
    tbl[1] = '{8'd1, 4, 64'h1122ED00_00000000, 2, 16'h2002, 1'b0, 2, 16'hFFFF, 1'b0};
    tbl[2] = '{8'd1, 5, 64'hED05AAED00_000000, 5, 16'h2005, 1'b0, 2, 16'hFFFF, 1'b1};
    tbl[3] = '{8'd2, 6, 64'hED01ED33ED00_0000, 2, 16'h2002, 1'b0, 2, 16'hFFFF, 1'b0};
    tbl[4] = '{8'd1, 5, 64'hED0477ED00_000000, 4, 16'h2004, 1'b0, 2, 16'hFFFF, 1'b1};
    tbl[5] = '{8'd1, 3, 64'h010203_0000000000, 3, 16'h2003, 1'b1, 2, 16'hFFFF, 1'b1};
    tbl[6] = '{8'd1, 2, 64'hED00_000000000000, 0, 16'h2000, 1'b0, 0, 16'hFFFE, 1'b0};
    tbl[7] = '{8'd1, 4, 64'h5AED0041_00000000, 1, 16'h2001, 1'b0, 1, 16'hFFFF, 1'b0};
    tbl[8] = '{8'd1, 3, 64'hED02ED_0000000000, 2, 16'h2002, 1'b1, 2, 16'hFFFF, 1'b1};

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = '0;
    ioctl_wr = 1'b0;
    ioctl_dout = '0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst/outs", {wait_a, en_a, wr_a, rst_a, err_a, data_a}, '0);
    check("rst/addr_a", addr_a, 16'h2000);
    check("rst/addr_b", addr_b, 16'hFFFE);

    for (int i = 0; i < 9; i++) begin
      strm.delete();
      tmp = tbl[i].bytes;
      for (int k = 0; k < int'(tbl[i].len); k++) strm.push_back(tmp[63-8*k -: 8]);
      run_vec($sformatf("tbl%0d", i), tbl[i].idx, 1'b0);
      check($sformatf("tbl%0d/n_a", i), cap_a.size(), tbl[i].n_a);
      check($sformatf("tbl%0d/addr_a", i), addr_a, tbl[i].addr_a);
      check($sformatf("tbl%0d/err_a", i), err_a, tbl[i].err_a);
      check($sformatf("tbl%0d/n_b", i), cap_b.size(), tbl[i].n_b);
      check($sformatf("tbl%0d/addr_b", i), addr_b, tbl[i].addr_b);
      check($sformatf("tbl%0d/err_b", i), err_b, tbl[i].err_b);
    end

    for (int r = 0; r < 8; r++) begin
      strm.delete();
      for (int t = 0; t < int'($urandom_range(3, 10)); t++) begin
        b = 8'($urandom);
        if (b == 8'hED) b = 8'h5E;
        case ($urandom_range(0, 3))
          0, 1: strm.push_back(b);
          2: begin
            strm.push_back(8'hED);
            strm.push_back(8'($urandom_range(1, 6)));
            strm.push_back(8'($urandom));
          end
          default: begin strm.push_back(8'hED); strm.push_back(8'h01); strm.push_back(8'hED); end
        endcase
      end
      if (r == 3) begin strm.push_back(8'hED); strm.push_back(8'hC8); strm.push_back(8'h3C); end
      case (r % 3)
        0: begin strm.push_back(8'hED); strm.push_back(8'h00); end
        1: begin strm.push_back(8'hED); strm.push_back(8'h00); strm.push_back(8'h77); end
        default: if (r == 2) strm.push_back(8'hED);
      endcase
      run_vec($sformatf("rnd%0d", r), (r == 5) ? 8'd0 : 8'($urandom_range(1, 255)), 1'b1);
    end

    // Literal latency, run timing, and a byte offered while wait is high.
    start_dl(8'd1, nr, nw);
    ioctl_dout = 8'h11;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("lat/wr", wr_a, 1);
    check("lat/addr", addr_a, 16'h2000);
    check("lat/data", data_a, 8'h11);
    @(negedge clk_sys);
    check("lat/wr_off", wr_a, 0);
    check("lat/addr_inc", addr_a, 16'h2001);
    send_byte(8'hED);
    send_byte(8'h05);
    send_byte(8'hAA);
    check("run/wait_c1", wait_a, 1);
    check("run/wr_c1", wr_a, 0);
    ioctl_dout = 8'h42;
    ioctl_wr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      check($sformatf("run/wr%0d", k), wr_a, 1);
      check($sformatf("run/addr%0d", k), addr_a, 16'h2001 + 16'(k));
      check($sformatf("run/data%0d", k), data_a, 8'hAA);
      check($sformatf("run/wait%0d", k), wait_a, 1);
    end
    @(negedge clk_sys);
    check("run/wait_drop", wait_a, 0);
    check("run/wr_end", wr_a, 0);
    check("run/addr_end", addr_a, 16'h2006);
    send_byte(8'hED);
    send_byte(8'h00);
    repeat (2) @(negedge clk_sys);
    check("run/addr_final", addr_a, 16'h2006);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("run/err", err_a, 0);

    // Download drops in the middle of a long run.
    start_dl(8'd3, nr, nw);
    send_byte(8'hED);
    send_byte(8'hFF);
    send_byte(8'h55);
    repeat (10) @(negedge clk_sys);
    check("drop/running", {wait_a, wr_a}, 2'b11);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("drop/en", en_a, 0);
    check("drop/wait", wait_a, 0);
    check("drop/wr", wr_a, 0);
    check("drop/err", err_a, 1);
    nc = cap_a.size();
    repeat (3) @(negedge clk_sys);
    check("drop/no_more_writes", cap_a.size(), nc);

    // Asynchronous reset while a run is in progress.
    start_dl(8'd1, nr, nw);
    send_byte(8'hED);
    send_byte(8'h10);
    send_byte(8'h66);
    repeat (4) @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    check("areset/outs", {wait_a, en_a, wr_a, rst_a, err_a, data_a}, '0);
    check("areset/addr_a", addr_a, 16'h2000);
    check("areset/addr_b", addr_b, 16'hFFFE);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("areset/idle", {wait_a, en_a, wr_a, rst_a}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
